// File: rtl/serial_word_transmitter.sv
// Parallel-to-serial word transmitter with valid/ready load, per-word bit order,
// bit stretching, optional inter-frame gap and frame start/last strobes.
module serial_word_transmitter #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] I_par,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             dir,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned BIT_LAST = WIDTH - 1;
    localparam int unsigned CYC_LAST = BIT_CYCLES - 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES != 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             dir_q, dir_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_last_q, frame_last_d;
    logic             busy_q, busy_d;
    logic             last_cyc, last_bit, accept;

    // Next-state logic; registered outputs are derived from the next state.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sh_d      = sh_q;
        dir_d     = dir_q;

        last_cyc   = (cyc_cnt_q == CW'(CYC_LAST));
        last_bit   = (bit_cnt_q == BW'(BIT_LAST));
        load_ready = reset && ((state_q == S_IDLE) ||
                     ((GAP_CYCLES == 0) && (state_q == S_SHIFT) && last_cyc && last_bit));
        accept     = load_valid && load_ready;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_SHIFT;
                    sh_d      = I_par;
                    dir_d     = dir;
                    bit_cnt_d = '0;
                    cyc_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                if (last_cyc) begin
                    cyc_cnt_d = '0;
                    if (last_bit) begin
                        // Frame ends: gap, back-to-back reload, or idle.
                        if (GAP_CYCLES != 0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                        end else if (accept) begin
                            sh_d      = I_par;
                            dir_d     = dir;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        sh_d      = dir_q ? (sh_q >> 1) : (sh_q << 1);
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(GAP_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        ser_valid_d   = (state_d == S_SHIFT);
        ser_out_d     = ser_valid_d && (dir_d ? sh_d[0] : sh_d[WIDTH-1]);
        frame_start_d = ser_valid_d && (bit_cnt_d == '0);
        frame_last_d  = ser_valid_d && (bit_cnt_d == BW'(BIT_LAST));
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            cyc_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            sh_q          <= '0;
            dir_q         <= 1'b0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            cyc_cnt_q     <= cyc_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            sh_q          <= sh_d;
            dir_q         <= dir_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_last_q  <= frame_last_d;
            busy_q        <= busy_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Bench for serial_word_transmitter: two instances (plain, stretched+gap) checked
// each cycle against a frame-index model plus directed literal expectations.
module tb_serial_word_transmitter;

    logic       clk = 1'b0;
    logic [1:0] rst = 2'b00;
    logic [1:0] lv  = 2'b00;
    logic [1:0] dr  = 2'b00;
    logic [3:0] ipar [2];
    logic [1:0] so, sv, fs, fl, bz, lr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_word_transmitter #(.WIDTH(4), .BIT_CYCLES(1), .GAP_CYCLES(0)) u_a (
        .clk(clk), .reset(rst[0]), .I_par(ipar[0]), .load_valid(lv[0]),
        .load_ready(lr[0]), .dir(dr[0]), .ser_out(so[0]), .ser_valid(sv[0]),
        .frame_start(fs[0]), .frame_last(fl[0]), .busy(bz[0]));

    serial_word_transmitter #(.WIDTH(4), .BIT_CYCLES(3), .GAP_CYCLES(2)) u_b (
        .clk(clk), .reset(rst[1]), .I_par(ipar[1]), .load_valid(lv[1]),
        .load_ready(lr[1]), .dir(dr[1]), .ser_out(so[1]), .ser_valid(sv[1]),
        .frame_start(fs[1]), .frame_last(fl[1]), .busy(bz[1]));

    // Model: a frame is 4*BC bit cycles followed by GC gap cycles, indexed by k.
    function automatic int bc(int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int gc(int i); return (i == 0) ? 0 : 2; endfunction
    function automatic int flen(int i); return 4 * bc(i) + gc(i); endfunction

    int         m_active [2];
    int         m_k      [2];
    logic [3:0] m_word   [2];
    logic       m_dir    [2];
    logic       started = 1'b0;

    function automatic logic m_ready(int i);
        return (m_active[i] == 0) || (gc(i) == 0 && m_k[i] == flen(i) - 1);
    endfunction

    // {ser_out, ser_valid, frame_start, frame_last, busy}
    function automatic logic [4:0] m_out(int i);
        int b;
        logic bitv;
        if (m_active[i] == 0) return 5'b00000;
        if (m_k[i] >= 4 * bc(i)) return 5'b00001;
        b = m_k[i] / bc(i);
        bitv = m_dir[i] ? m_word[i][b] : m_word[i][3 - b];
        return {bitv, 1'b1, (b == 0), (b == 3), 1'b1};
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_k[i] = 0; m_word[i] = '0; m_dir[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst[i]) begin
                    m_active[i] = 0;
                end else begin
                    logic r;
                    r = m_ready(i);
                    if (m_active[i] != 0) begin
                        m_k[i] = m_k[i] + 1;
                        if (m_k[i] >= flen(i)) m_active[i] = 0;
                    end
                    if (lv[i] && r) begin
                        m_active[i] = 1; m_k[i] = 0;
                        m_word[i] = ipar[i]; m_dir[i] = dr[i];
                    end
                end
            end
            started = 1'b1;
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                for (int i = 0; i < 2; i++) begin
                    logic [4:0] got;
                    got = {so[i], sv[i], fs[i], fl[i], bz[i]};
                    n_checks++;
                    if (got !== m_out(i)) begin
                        n_fail++;
                        $display("FAIL model_out[%0d] t=%0t got=%b exp=%b", i, $time, got, m_out(i));
                    end
                    if (rst[i]) begin
                        n_checks++;
                        if (lr[i] !== m_ready(i)) begin
                            n_fail++;
                            $display("FAIL model_ready[%0d] t=%0t got=%b exp=%b", i, $time, lr[i], m_ready(i));
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // Checks one directed 4-bit frame on instance A, first bit already on the line.
    task automatic frame_a(input string name, input logic [3:0] seq);
        for (int c = 0; c < 4; c++) begin
            chk({name, "_bit"}, 8'(so[0]), 8'(seq[3 - c]));
            chk({name, "_sv"}, 8'(sv[0]), 8'h1);
            chk({name, "_fs"}, 8'(fs[0]), 8'((c == 0) ? 1 : 0));
            chk({name, "_fl"}, 8'(fl[0]), 8'((c == 3) ? 1 : 0));
            step();
        end
        chk({name, "_end_busy"}, 8'(bz[0]), 8'h0);
        chk({name, "_end_sv"}, 8'(sv[0]), 8'h0);
    endtask

    initial begin
        logic [7:0]  b2b;
        logic [11:0] stretch;
        ipar[0] = 4'h0;
        ipar[1] = 4'h0;

        // 1: reset held two edges with a word offered
        lv[0] = 1'b1; ipar[0] = 4'hF;
        step(); step();
        chk("rst_sv", 8'(sv[0]), 8'h0);
        chk("rst_so", 8'(so[0]), 8'h0);
        chk("rst_busy", 8'(bz[0]), 8'h0);
        rst = 2'b11; lv[0] = 1'b0;
        #1;
        chk("rst_ready", 8'(lr[0]), 8'h1);
        step();
        chk("rst_noaccept", 8'(bz[0]), 8'h0);

        // 2: MSB-first
        lv[0] = 1'b1; ipar[0] = 4'b1011; dr[0] = 1'b0;
        step();
        lv[0] = 1'b0;
        frame_a("msb", 4'b1011);

        // 3: LSB-first; inputs changed mid-frame must not matter
        lv[0] = 1'b1; ipar[0] = 4'b1011; dr[0] = 1'b1;
        step();
        lv[0] = 1'b0; ipar[0] = 4'h3; dr[0] = 1'b0;
        frame_a("lsb", 4'b1101);

        // 4: back-to-back frames with load_valid held
        b2b = 8'b1010_0101;
        lv[0] = 1'b1; ipar[0] = 4'hA; dr[0] = 1'b0;
        step();
        ipar[0] = 4'h5;
        for (int c = 0; c < 8; c++) begin
            chk("b2b_bit", 8'(so[0]), 8'(b2b[7 - c]));
            chk("b2b_sv", 8'(sv[0]), 8'h1);
            chk("b2b_fs", 8'(fs[0]), 8'((c == 0 || c == 4) ? 1 : 0));
            if (c < 4) chk("b2b_ready", 8'(lr[0]), 8'((c == 3) ? 1 : 0));
            step();
            if (c == 3) lv[0] = 1'b0;
        end
        chk("b2b_end_busy", 8'(bz[0]), 8'h0);

        // 5: stretched bits and gap on instance B
        stretch = 12'b111_000_000_111;
        lv[1] = 1'b1; ipar[1] = 4'b1001; dr[1] = 1'b0;
        step();
        lv[1] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            chk("str_bit", 8'(so[1]), 8'(stretch[11 - c]));
            chk("str_sv", 8'(sv[1]), 8'h1);
            step();
        end
        for (int c = 0; c < 2; c++) begin
            chk("gap_busy", 8'(bz[1]), 8'h1);
            chk("gap_ready", 8'(lr[1]), 8'h0);
            chk("gap_sv", 8'(sv[1]), 8'h0);
            step();
        end
        chk("gap_end_ready", 8'(lr[1]), 8'h1);
        chk("gap_end_busy", 8'(bz[1]), 8'h0);

        // 6: mid-frame reset, then a fresh all-zero frame
        lv[0] = 1'b1; ipar[0] = 4'hF; dr[0] = 1'b0;
        step();
        lv[0] = 1'b0; ipar[0] = 4'h3;
        chk("abort_bit0", 8'(so[0]), 8'h1);
        step();
        chk("abort_bit1", 8'(so[0]), 8'h1);
        rst[0] = 1'b0;
        step();
        chk("abort_sv", 8'(sv[0]), 8'h0);
        chk("abort_busy", 8'(bz[0]), 8'h0);
        chk("abort_so", 8'(so[0]), 8'h0);
        rst[0] = 1'b1; lv[0] = 1'b1; ipar[0] = 4'h0;
        step();
        lv[0] = 1'b0;
        frame_a("fresh", 4'b0000);

        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
